ua_rx_word: RTL and testbench

Serial receiver that sits directly downstream of the PRNG serial transmitter. It takes the transmitter's serial line, recovers 8N1 bytes at the baud rate chosen by `baud_sel`, and reassembles each group of four bytes into the 32-bit PRNG word that was sent. Its purpose is to give a board-level or bench-level loopback check of the random stream.

---
 rtl/ua_rx_word_pkg.sv | 18 +
 rtl/ua_rx_tick.sv | 22 ++
 rtl/ua_rx_word.sv | 94 +++++++++
 tb/tb_ua_rx_word.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ua_rx_word_pkg.sv
// ua_rx_word_pkg: shared receiver states, baud table and 16x divisor helpers
package ua_rx_word_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
  localparam int DIV_W = 16;
  typedef logic [7:0][DIV_W-1:0] div_tbl_t;
  localparam int unsigned BAUD [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz, input logic [2:0] sel);
    logic [63:0] b, d;
    b = 64'(BAUD[sel]);
    d = (64'(clk_hz) + 64'd8 * b) / (64'd16 * b);
    return (d == 64'd0) ? DIV_W'(1) : DIV_W'(d);
  endfunction
  function automatic div_tbl_t div_table(input int unsigned clk_hz);
    div_tbl_t t;
    for (int i = 0; i < 8; i++) t[i] = baud_div(clk_hz, 3'(i));
    return t;
  endfunction
endpackage

// File: rtl/ua_rx_tick.sv
// ua_rx_tick: 16x baud tick generator, restarted by load with a new divisor
module ua_rx_tick
  import ua_rx_word_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] period, cnt;
  assign tick = !load && cnt == '0;
  always_ff @(posedge clk)
    if (reset) begin
      period <= DIV_W'(1);
      cnt <= '0;
    end else if (load) begin
      period <= div;
      cnt <= div - DIV_W'(1);
    end else
      cnt <= (cnt == '0) ? period - DIV_W'(1) : cnt - DIV_W'(1);
endmodule

// File: rtl/ua_rx_word.sv
// ua_rx_word: 8N1 receiver reassembling little-endian 32-bit words with idle resync
module ua_rx_word
  import ua_rx_word_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned IDLE_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic [2:0]  baud_sel,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        frame_err,
  output logic        word_abort,
  output logic        rx_busy
);
  localparam div_tbl_t DIVS = div_table(CLK_HZ);
  localparam int IDLE_TICKS = IDLE_BITS * 16;
  localparam int IW = $clog2(IDLE_TICKS + 1);
  rx_state_t state, state_nxt;
  logic s1, s2, s3;
  logic fall, load, tick, samp, good, bad, timeout;
  logic [3:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic [1:0] idx;
  logic [23:0] wbuf;
  logic [IW-1:0] icnt;
  assign fall = s3 & ~s2;
  assign load = state == IDLE && fall;
  assign samp = tick && tcnt == (state == START ? 4'd7 : 4'd15);
  assign good = state == STOP && samp && s2;
  assign bad = state == STOP && samp && !s2;
  // a start edge in the same cycle as the timeout takes priority
  assign timeout = state == IDLE && idx != 2'd0 && tick && icnt == IW'(IDLE_TICKS - 1) && !fall;
  assign rx_busy = state != IDLE;
  ua_rx_tick u_tick (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .div  (DIVS[baud_sel]),
    .tick (tick)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = fall ? START : IDLE;
      START:     state_nxt = samp ? (s2 ? IDLE : DATA) : START;
      DATA:      state_nxt = (samp && bcnt == 3'd7) ? STOP : DATA;
      STOP:      state_nxt = samp ? (s2 ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: state_nxt = s2 ? IDLE : WAIT_HIGH;
      default:   state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      {s1, s2, s3} <= 3'b111;
      tcnt <= '0;
      bcnt <= '0;
      shreg <= '0;
      idx <= '0;
      wbuf <= '0;
      icnt <= '0;
      byte_out <= '0;
      word_out <= '0;
      byte_valid <= 1'b0;
      word_valid <= 1'b0;
      frame_err <= 1'b0;
      word_abort <= 1'b0;
    end else begin
      {s1, s2, s3} <= {bit_in, s1, s2};
      tcnt <= (load || (state == START && samp)) ? 4'd0 : tick ? tcnt + 4'd1 : tcnt;
      bcnt <= load ? 3'd0 : (state == DATA && samp) ? bcnt + 3'd1 : bcnt;
      if (state == DATA && samp) shreg <= {s2, shreg[7:1]};
      icnt <= (fall || timeout) ? '0 : (state == IDLE && idx != 2'd0 && tick) ? icnt + IW'(1) : icnt;
      byte_valid <= good;
      word_valid <= good && idx == 2'd3;
      frame_err <= bad;
      word_abort <= (bad && idx != 2'd0) || timeout;
      if (good) begin
        byte_out <= shreg;
        wbuf <= {shreg, wbuf[23:8]};
        idx <= idx + 2'd1;
        if (idx == 2'd3) word_out <= {shreg, wbuf};
      end
      if (bad || timeout) idx <= 2'd0;
    end
endmodule

// File: tb/tb_ua_rx_word.sv
// tb_ua_rx_word: randomized serial stimulus checked against a frame-level word model
module tb_ua_rx_word;
  localparam int unsigned CLK_HZ = 7_372_800;
  localparam int unsigned IDLE_BITS = 16;
  logic clk = 1'b0, reset = 1'b1, bit_in = 1'b1;
  logic [2:0] baud_sel = 3'd0;
  logic [7:0] byte_out;
  logic [31:0] word_out;
  logic byte_valid, word_valid, frame_err, word_abort, rx_busy;
  int checks = 0, errors = 0;
  int exp_fe = 0, exp_ab = 0, exp_feab = 0, act_fe = 0, act_ab = 0, act_feab = 0;
  int partial = 0;
  logic [31:0] acc = '0;
  logic [7:0] last_byte = '0;
  logic [31:0] last_word = '0;
  logic [7:0] exp_bytes [$];
  logic [31:0] exp_words [$];
  ua_rx_word #(.CLK_HZ(CLK_HZ), .IDLE_BITS(IDLE_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .baud_sel  (baud_sel),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .word_out  (word_out),
    .word_valid(word_valid),
    .frame_err (frame_err),
    .word_abort(word_abort),
    .rx_busy   (rx_busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int bit_clks(input logic [2:0] sel);
    int bauds [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
    return 16 * $rtoi(real'(CLK_HZ) / (16.0 * bauds[sel]) + 0.5);
  endfunction
  task automatic drive(input logic v, input int n);
    bit_in = v;
    repeat (n) @(posedge clk);
  endtask
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_bytes.push_back(b);
      last_byte = b;
      acc[8 * partial +: 8] = b;
      partial++;
      if (partial == 4) begin
        exp_words.push_back(acc);
        last_word = acc;
        partial = 0;
      end
    end else begin
      exp_fe++;
      if (partial != 0) begin
        exp_ab++;
        exp_feab++;
      end
      partial = 0;
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic [2:0] sel);
    int n;
    n = bit_clks(sel);
    baud_sel = sel;
    drive(1'b0, n);
    for (int i = 0; i < 8; i++) drive(b[i], n);
    model_frame(b, stop);
    drive(stop, n);
    bit_in = 1'b1;
  endtask
  task automatic idle(input int bits, input logic [2:0] sel);
    if (bits >= int'(IDLE_BITS) && partial != 0) begin
      exp_ab++;
      partial = 0;
    end
    drive(1'b1, bits * bit_clks(sel));
  endtask
  task automatic send_word(input logic [31:0] w, input logic [2:0] sel, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_frame(w[8 * i +: 8], 1'b1, sel);
      idle(gap, sel);
    end
  endtask
  task automatic end_checks(input string tag);
    @(negedge clk);
    check({tag, "_byte_out"}, 32'(byte_out), 32'(last_byte));
    check({tag, "_word_out"}, word_out, last_word);
    check({tag, "_frame_errs"}, act_fe, exp_fe);
    check({tag, "_aborts"}, act_ab, exp_ab);
    check({tag, "_fe_with_abort"}, act_feab, exp_feab);
    check({tag, "_bytes_left"}, exp_bytes.size(), 0);
    check({tag, "_words_left"}, exp_words.size(), 0);
    check({tag, "_busy"}, 32'(rx_busy), 0);
  endtask
  always @(negedge clk) begin
    if (byte_valid) begin
      if (exp_bytes.size() == 0) check("byte_extra", 32'(byte_valid), 0);
      else check("byte", 32'(byte_out), 32'(exp_bytes.pop_front()));
    end
    if (word_valid) begin
      check("word_with_byte", 32'(byte_valid), 1);
      if (exp_words.size() == 0) check("word_extra", 32'(word_valid), 0);
      else check("word", word_out, exp_words.pop_front());
    end
    if (frame_err) begin
      act_fe++;
      if (word_abort) act_feab++;
    end
    if (word_abort) act_ab++;
  end
  initial begin
    logic [7:0] b;
    logic [2:0] sel;
    logic stop, busy_seen;
    int gap, n;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_byte_out", 32'(byte_out), 0);
    check("rst_word_out", word_out, 0);
    check("rst_flags", {27'd0, byte_valid, word_valid, frame_err, word_abort, rx_busy}, 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    send_word(32'h7B81_F135, 3'd4, 1);
    idle(2, 3'd4);
    end_checks("loopback");
    check("loopback_word", word_out, 32'h7B81_F135);
    for (int s = 0; s < 8; s++) begin
      send_word(32'hA5A5_5A5A, 3'(s), 0);
      idle(2, 3'(s));
      @(negedge clk);
      check($sformatf("sweep%0d_word", s), word_out, 32'hA5A5_5A5A);
    end
    end_checks("sweep");
    baud_sel = 3'd5;
    busy_seen = 1'b0;
    bit_in = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 busy_seen |= rx_busy;
    end
    bit_in = 1'b1;
    for (int i = 0; i < 20 && rx_busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("glitch_busy_seen", 32'(busy_seen), 1);
    check("glitch_busy_clear", 32'(rx_busy), 0);
    idle(2, 3'd5);
    end_checks("glitch");
    for (int i = 0; i < 2; i++) begin
      send_frame(8'($urandom), 1'b1, 3'd6);
      idle(1, 3'd6);
    end
    send_frame(8'h3C, 1'b0, 3'd6);
    idle(2, 3'd6);
    send_word($urandom, 3'd6, 1);
    idle(2, 3'd6);
    end_checks("framing");
    for (int i = 0; i < 2; i++) begin
      send_frame(8'($urandom), 1'b1, 3'd7);
      idle(1, 3'd7);
    end
    idle(17, 3'd7);
    send_word($urandom, 3'd7, 1);
    idle(2, 3'd7);
    end_checks("timeout");
    send_frame(8'($urandom_range(1, 255)), 1'b1, 3'd7);
    idle(1, 3'd7);
    b = 8'($urandom);
    n = bit_clks(3'd7);
    baud_sel = 3'd7;
    drive(1'b0, n);
    for (int i = 0; i < 3; i++) drive(b[i], n);
    drive(b[3], n / 2);
    @(negedge clk);
    reset = 1'b1;
    bit_in = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_byte_out", 32'(byte_out), 0);
    check("midrst_word_out", word_out, 0);
    check("midrst_flags", {27'd0, byte_valid, word_valid, frame_err, word_abort, rx_busy}, 0);
    reset = 1'b0;
    partial = 0;
    last_byte = '0;
    last_word = '0;
    idle(2, 3'd7);
    send_word($urandom, 3'd7, 1);
    idle(2, 3'd7);
    end_checks("midrst");
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      sel = 3'($urandom_range(6, 7));
      stop = $urandom_range(0, 7) != 0;
      gap = ($urandom_range(0, 5) == 0) ? $urandom_range(17, 19) : $urandom_range(stop ? 0 : 1, 3);
      send_frame(b, stop, sel);
      idle(gap, sel);
    end
    idle(2, 3'd6);
    end_checks("random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
